seq_serializer: RTL and testbench

upstream stage for the serial sequence detectors. Converts parallel words from a valid/ready source into a gap-free serial bit stream on x, one bit per clock.

Interface

---
 rtl/seq_serializer.sv | 104 ++++++++++
 tb/tb_seq_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word skid (hold) register, feeding the
// serial sequence detectors with a gap-free bit stream on x.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             head;
    logic [WIDTH-1:0] shifted;

    assign din_ready = rst & ~hold_full_q;
    assign accept    = din_valid & din_ready;

    assign head    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    assign x_valid   = (state_q == StShift);
    assign x         = x_valid & head;
    assign frame_end = x_valid & (cnt_q == CntLast);
    assign busy      = x_valid | hold_full_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != CntLast) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    // Last bit: reload without a gap, held word first.
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shreg_d = hold_q;
                        if (accept) begin
                            hold_d = din;
                        end else begin
                            hold_full_d = 1'b0;
                        end
                    end else if (accept) begin
                        shreg_d = din;
                    end else begin
                        shreg_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed and randomized self-checking bench for seq_serializer (MSB-first and
// LSB-first instances).
module tb_seq_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din, din_b;
    logic         din_valid, din_valid_b;
    logic         din_ready, x, x_valid, frame_end, busy;
    logic         din_ready_b, x_b, x_valid_b, frame_end_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .frame_end (frame_end),
        .busy      (busy)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din_b),
        .din_valid (din_valid_b),
        .din_ready (din_ready_b),
        .x         (x_b),
        .x_valid   (x_valid_b),
        .frame_end (frame_end_b),
        .busy      (busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        din = 8'hFF;
        din_valid = 1'b1;
        din_b = 8'hFF;
        din_valid_b = 1'b0;
        #2;
        n_checks++;
        if ({x, x_valid, frame_end, busy, din_ready} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_async: got %b expected 00000",
                     {x, x_valid, frame_end, busy, din_ready});
        end
        step();
        step();
        n_checks++;
        if ({x, x_valid, frame_end, busy, din_ready} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_held: got %b expected 00000",
                     {x, x_valid, frame_end, busy, din_ready});
        end
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({din_ready, busy, x_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected 100", {din_ready, busy, x_valid});
        end
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        w = 8'hB0;
        din = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({x_valid, x, frame_end} !== {1'b1, w[7-i], (i == 7)}) begin
                n_errors++;
                $display("FAIL single_bit%0d: got %b expected %b", i,
                         {x_valid, x, frame_end}, {1'b1, w[7-i], (i == 7)});
            end
            step();
        end
        n_checks++;
        if ({x_valid, busy, x, frame_end} !== 4'b0) begin
            n_errors++;
            $display("FAIL single_idle: got %b expected 0000", {x_valid, busy, x, frame_end});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        s = 16'b1011_1011_0000_1011;
        din = 8'hBB;
        din_valid = 1'b1;
        step();
        din = 8'h0B;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({x_valid, x, frame_end} !== {1'b1, s[15-i], (i == 7 || i == 15)}) begin
                n_errors++;
                $display("FAIL b2b_bit%0d: got %b expected %b", i,
                         {x_valid, x, frame_end}, {1'b1, s[15-i], (i == 7 || i == 15)});
            end
            step();
            if (i == 0) din_valid = 1'b0;
        end
        n_checks++;
        if ({x_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL b2b_idle: got %b expected 00", {x_valid, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] s;
        logic        exp_rdy;
        s = {8'hA5, 8'h3C, 8'hF0};
        din = 8'hA5;
        din_valid = 1'b1;
        step();
        din = 8'h3C;
        for (int p = 0; p < 24; p++) begin
            exp_rdy = (p == 0) || (p == 8) || (p >= 16);
            n_checks++;
            if ({x_valid, x, frame_end, din_ready} !==
                {1'b1, s[23-p], (p % 8 == 7), exp_rdy}) begin
                n_errors++;
                $display("FAIL bp_cycle%0d: got %b expected %b", p,
                         {x_valid, x, frame_end, din_ready},
                         {1'b1, s[23-p], (p % 8 == 7), exp_rdy});
            end
            step();
            if (p == 0) din = 8'hF0;
            if (p == 8) din_valid = 1'b0;
        end
        n_checks++;
        if ({x_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL bp_idle: got %b expected 00", {x_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        din = 8'hAA;
        step();
        din_valid = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if ({x_valid, busy, x} !== 3'b111) begin
            n_errors++;
            $display("FAIL rstmid_before: got %b expected 111", {x_valid, busy, x});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({x, x_valid, frame_end, busy, din_ready} !== 5'b0) begin
            n_errors++;
            $display("FAIL rstmid_async: got %b expected 00000",
                     {x, x_valid, frame_end, busy, din_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({din_ready, busy, x_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL rstmid_release: got %b expected 100", {din_ready, busy, x_valid});
        end
        w = 8'h0D;
        din = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({x_valid, x, frame_end} !== {1'b1, w[7-i], (i == 7)}) begin
                n_errors++;
                $display("FAIL rstmid_bit%0d: got %b expected %b", i,
                         {x_valid, x, frame_end}, {1'b1, w[7-i], (i == 7)});
            end
            step();
        end
        n_checks++;
        if ({x_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL rstmid_idle: got %b expected 00", {x_valid, busy});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] e;
        e = 8'b1011_0000;
        din_b = 8'h0D;
        din_valid_b = 1'b1;
        step();
        din_valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({x_valid_b, x_b, frame_end_b} !== {1'b1, e[7-i], (i == 7)}) begin
                n_errors++;
                $display("FAIL lsb_bit%0d: got %b expected %b", i,
                         {x_valid_b, x_b, frame_end_b}, {1'b1, e[7-i], (i == 7)});
            end
            step();
        end
        n_checks++;
        if ({x_valid_b, busy_b} !== 2'b00) begin
            n_errors++;
            $display("FAIL lsb_idle: got %b expected 00", {x_valid_b, busy_b});
        end
    endtask

    // Reference: a queue of pending bits; the hold slot is free while at most one
    // word's worth of bits is outstanding.
    task automatic test_random();
        bit   q[$];
        int   words = 0;
        int   cyc = 0;
        int   n;
        logic e_v, e_x, e_fe, e_busy, e_rdy, acc;
        while (words < 1000 || q.size() > 0) begin
            if (cyc >= 40000) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_timeout: got %0d words expected 1000", words);
                break;
            end
            if (words < 1000) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = 8'($urandom);
            end else begin
                din_valid = 1'b0;
            end
            n      = q.size();
            e_v    = (n > 0);
            e_x    = e_v ? q[0] : 1'b0;
            e_fe   = e_v && ((n - 1) % W == 0);
            e_busy = e_v;
            e_rdy  = (n <= W);
            n_checks++;
            if ({x_valid, x, frame_end, busy, din_ready} !== {e_v, e_x, e_fe, e_busy, e_rdy}) begin
                n_errors++;
                $display("FAIL rand_cycle%0d: got %b expected %b", cyc,
                         {x_valid, x, frame_end, busy, din_ready},
                         {e_v, e_x, e_fe, e_busy, e_rdy});
            end
            acc = din_valid && e_rdy;
            if (n > 0) void'(q.pop_front());
            if (acc) begin
                for (int b = W - 1; b >= 0; b--) q.push_back(din[b]);
                words++;
            end
            step();
            cyc++;
        end
        din_valid = 1'b0;
        n_checks++;
        if ({x_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL rand_idle: got %b expected 00", {x_valid, busy});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_lsb_first();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
